// File: rtl/mrv1_ifetch.sv
// Instruction fetch front-end: credit-limited sequential fetch, in-order buffer, epoch-tagged redirect flush.
// Optional MRV1_IFETCH_PERF_EN adds saturating stall/drop performance counters.
module mrv1_ifetch #(
    parameter int          IMEM_TAG_WIDTH_P = 2,
    parameter int          fifo_depth_p     = 4,
    parameter logic [31:0] reset_pc_p       = 32'h0000_0000
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        redirect_vld_i,
    input  logic [31:0]                 redirect_pc_i,
    output logic                        imem_req_vld_o,
    input  logic                        imem_req_rdy_i,
    output logic [IMEM_TAG_WIDTH_P-1:0] imem_req_tag_o,
    output logic [31:0]                 imem_req_addr_o,
    input  logic                        imem_resp_vld_i,
    input  logic [31:0]                 imem_resp_data_i,
    input  logic [IMEM_TAG_WIDTH_P-1:0] imem_resp_tag_i,
`ifdef MRV1_IFETCH_PERF_EN
    output logic [31:0]                 perf_stall_cnt_o,
    output logic [31:0]                 perf_drop_cnt_o,
`endif
    output logic                        instr_vld_o,
    input  logic                        instr_rdy_i,
    output logic [31:0]                 instr_pc_o,
    output logic [31:0]                 instr_data_o
);
    localparam int PTR_W = (fifo_depth_p > 1) ? $clog2(fifo_depth_p) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]                 fetch_pc_q, fetch_pc_d;
    logic [31:0]                 out_pc_q, out_pc_d;
    logic [IMEM_TAG_WIDTH_P-1:0] epoch_q, epoch_d;
    logic [CNT_W-1:0]            outstanding_q, outstanding_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic                        rst_dly_q;
    logic [31:0]                 buf_q [fifo_depth_p];

    logic        credit_ok;
    logic        req_fire;
    logic        resp_live;
    logic        push;
    logic        pop;
    logic        drop;
    logic [31:0] redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc_i & ~32'h3;
    // Reserve a buffer slot for every request in flight so a response can never overflow.
    assign credit_ok       = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CNT_W + 1)'(fifo_depth_p);
    assign imem_req_vld_o  = !rst_i && !redirect_vld_i && credit_ok;
    assign imem_req_addr_o = fetch_pc_q;
    assign imem_req_tag_o  = epoch_q;
    assign req_fire        = imem_req_vld_o && imem_req_rdy_i;

    // The cycle right after reset may still see a response to a pre-reset request.
    assign resp_live = imem_resp_vld_i && !rst_i && !rst_dly_q;
    assign push      = resp_live && (imem_resp_tag_i == epoch_q) && !redirect_vld_i;
    assign drop      = resp_live && !push;

    assign instr_vld_o  = (count_q != '0);
    assign instr_pc_o   = out_pc_q;
    assign instr_data_o = buf_q[rd_ptr_q];
    assign pop          = instr_vld_o && instr_rdy_i && !redirect_vld_i;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        out_pc_d      = out_pc_q;
        epoch_d       = epoch_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_live);
        if (redirect_vld_i) begin
            fetch_pc_d = redirect_pc_aligned;
            out_pc_d   = redirect_pc_aligned;
            epoch_d    = epoch_q + 1'b1;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (pop) begin
                out_pc_d = out_pc_q + 32'd4;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= reset_pc_p;
            out_pc_q      <= reset_pc_p;
            epoch_q       <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rst_dly_q     <= 1'b1;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            out_pc_q      <= out_pc_d;
            epoch_q       <= epoch_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rst_dly_q     <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) buf_q[wr_ptr_q] <= imem_resp_data_i;
    end

`ifdef MRV1_IFETCH_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_drop_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            if (!instr_vld_o && perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
            if (drop && perf_drop_q != 32'hFFFF_FFFF) perf_drop_q <= perf_drop_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = perf_stall_q;
    assign perf_drop_cnt_o  = perf_drop_q;
`endif

endmodule
